// File: rtl/quadrilatero_rf_row_reader.sv
// quadrilatero_rf_row_reader: streams one matrix register row by row through a 2-entry FIFO (optional write-hazard hold via QUADRILATERO_RF_READER_HAZARD_EN)
module quadrilatero_rf_row_reader #(
  parameter int N_REGS = 8,
  parameter int RLEN   = 128,
  parameter int ID_W   = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [$clog2(N_REGS)-1:0]         req_reg_i,
  input  logic [ID_W-1:0]                   req_id_i,
  input  logic                              flush_i,
  output logic [$clog2(N_REGS)-1:0]         rf_raddr_o,
  output logic [$clog2(RLEN/32)-1:0]        rf_rrowaddr_o,
  input  logic [RLEN-1:0]                   rf_rdata_i,
  input  logic [N_REGS-1:0]                 rf_wbusy_i,
  output logic                              row_valid_o,
  input  logic                              row_ready_i,
  output logic [RLEN-1:0]                   row_data_o,
  output logic [$clog2(RLEN/32)-1:0]        row_idx_o,
  output logic [ID_W-1:0]                   row_id_o,
  output logic                              row_last_o,
  output logic                              busy_o
);
  localparam int N_ROWS = RLEN / 32;
  localparam int RW = $clog2(N_REGS);
  localparam int CW = $clog2(N_ROWS);
  localparam logic [1:0] IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2;
`ifdef QUADRILATERO_RF_READER_HAZARD_EN
  localparam logic [1:0] HOLD = 2'd3;
`endif

  logic [1:0]      state, state_d, start;
  logic [RW-1:0]   reg_q;
  logic [ID_W-1:0] id_q;
  logic [CW-1:0]   cnt;
  logic [RLEN-1:0] fd  [2];
  logic [CW-1:0]   fi  [2];
  logic [ID_W-1:0] fid [2];
  logic            fl  [2];
  logic            wp, rp;
  logic [1:0]      fcnt;
  logic            accept, pop, push, last_row, drained, hold_go;

`ifdef QUADRILATERO_RF_READER_HAZARD_EN
  assign start   = HOLD;
  assign hold_go = state == HOLD && !rf_wbusy_i[reg_q];
`else
  logic unused_wbusy;
  assign unused_wbusy = ^rf_wbusy_i;
  assign start   = STREAM;
  assign hold_go = 1'b0;
`endif

  assign req_ready_o   = state == IDLE && !flush_i;
  assign accept        = req_valid_i && req_ready_o;
  assign pop           = row_valid_o && row_ready_i;
  assign last_row      = cnt == CW'(N_ROWS - 1);
  assign push          = state == STREAM && !flush_i && (fcnt != 2'd2 || pop);
  assign drained       = fcnt == 2'd0 || (fcnt == 2'd1 && pop);
  assign rf_raddr_o    = reg_q;
  assign rf_rrowaddr_o = cnt;
  assign row_valid_o   = fcnt != 2'd0;
  assign row_data_o    = fd[rp];
  assign row_idx_o     = fi[rp];
  assign row_id_o      = fid[rp];
  assign row_last_o    = fl[rp];
  assign busy_o        = state != IDLE || row_valid_o;

  // next state: flush wins, then accept, end of stream, drain completion, hazard release
  always_comb
    state_d = flush_i                             ? IDLE   :
              accept                              ? start  :
              (push && last_row)                  ? DRAIN  :
              (state == DRAIN && drained)         ? IDLE   :
              hold_go                             ? STREAM : state;

  // request latch, row counter and state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      reg_q <= '0;
      id_q  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        reg_q <= req_reg_i;
        id_q  <= req_id_i;
      end
      cnt <= (flush_i || accept) ? '0 : (push && !last_row) ? cnt + CW'(1) : cnt;
    end

  // 2-entry output FIFO decoupling consumer back-pressure from the regfile read
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp   <= 1'b0;
      rp   <= 1'b0;
      fcnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fd[i]  <= '0;
        fi[i]  <= '0;
        fid[i] <= '0;
        fl[i]  <= 1'b0;
      end
    end else if (flush_i) begin
      wp   <= 1'b0;
      rp   <= 1'b0;
      fcnt <= 2'd0;
    end else begin
      if (push) begin
        fd[wp]  <= rf_rdata_i;
        fi[wp]  <= cnt;
        fid[wp] <= id_q;
        fl[wp]  <= last_row;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      fcnt <= fcnt + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: tb/tb_quadrilatero_rf_row_reader.sv
// tb_quadrilatero_rf_row_reader: directed self-checking bench for the regfile row reader
module tb_quadrilatero_rf_row_reader;
`ifdef QUADRILATERO_RF_READER_HAZARD_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk = 1'b0, rst = 1'b1;
  logic         req_valid = 1'b0, req_ready, flush = 1'b0;
  logic [2:0]   req_reg = '0, rf_raddr;
  logic [1:0]   req_id = '0, rf_rrowaddr, row_idx, row_id;
  logic [127:0] rf_rdata, row_data;
  logic [7:0]   wbusy = '0;
  logic         row_valid, row_ready = 1'b0, row_last, busy;
  logic [5:0]   pat = 6'b101001;
  int           total = 0, passed = 0, fails = 0, n, acc;
  logic         go;
  logic [2:0]   nr;

  always #5 clk = ~clk;

  function automatic logic [127:0] rowval(input logic [2:0] r, input logic [1:0] i);
    return {16{{1'b0, r}, {2'b0, i}}};
  endfunction

  assign rf_rdata = rowval(rf_raddr, rf_rrowaddr);

  quadrilatero_rf_row_reader dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_reg_i(req_reg), .req_id_i(req_id), .flush_i(flush),
    .rf_raddr_o(rf_raddr), .rf_rrowaddr_o(rf_rrowaddr), .rf_rdata_i(rf_rdata),
    .rf_wbusy_i(wbusy), .row_valid_o(row_valid), .row_ready_i(row_ready),
    .row_data_o(row_data), .row_idx_o(row_idx), .row_id_o(row_id),
    .row_last_o(row_last), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic run_basic(input logic [2:0] r, input logic [1:0] id);
    row_ready = 1'b1; req_reg = r; req_id = id; req_valid = 1'b1; #1;
    chk("acc_ready", 128'(req_ready), 128'd1);
    tick; req_valid = 1'b0; #1;
    chk("t1_valid", 128'(row_valid), 128'd0);
    chk("t1_busy", 128'(busy), 128'd1);
    chk("t1_req_ready", 128'(req_ready), 128'd0);
    chk("t1_raddr", 128'(rf_raddr), 128'(r));
    chk("t1_rowaddr", 128'(rf_rrowaddr), 128'd0);
    for (int k = 0; k < EXTRA; k++) begin
      tick; #1;
      chk("hold_valid", 128'(row_valid), 128'd0);
    end
    tick;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("row_valid", 128'(row_valid), 128'd1);
      chk("row_idx", 128'(row_idx), 128'(i));
      chk("row_data", row_data, rowval(r, 2'(i)));
      chk("row_id", 128'(row_id), 128'(id));
      chk("row_last", 128'(row_last), 128'(i == 3));
      tick;
    end
    #1;
    chk("end_req_ready", 128'(req_ready), 128'd1);
    chk("end_valid", 128'(row_valid), 128'd0);
    chk("end_busy", 128'(busy), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tick; tick; #1;
    chk("rst_req_ready", 128'(req_ready), 128'd1);
    chk("rst_valid", 128'(row_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_raddr", 128'(rf_raddr), 128'd0);
    chk("rst_data", row_data, 128'd0);
    tick; rst = 1'b0; tick;

    run_basic(3'd3, 2'd2);

    row_ready = 1'b0; req_reg = 3'd6; req_id = 2'd1; req_valid = 1'b1;
    tick; req_valid = 1'b0;
    repeat (3 + EXTRA) tick;
    #1;
    chk("bp_stall_rowaddr", 128'(rf_rrowaddr), 128'd2);
    chk("bp_head_valid", 128'(row_valid), 128'd1);
    chk("bp_head_idx", 128'(row_idx), 128'd0);
    tick; #1;
    chk("bp_still_stalled", 128'(rf_rrowaddr), 128'd2);
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      row_ready = pat[k % 6]; #1;
      if (row_valid && row_ready) begin
        chk("bp_idx", 128'(row_idx), 128'(n));
        chk("bp_data", row_data, rowval(3'd6, 2'(n)));
        chk("bp_id", 128'(row_id), 128'd1);
        chk("bp_last", 128'(row_last), 128'(n == 3));
        n++;
      end
      tick;
    end
    row_ready = 1'b1; #1;
    chk("bp_rows", 128'(n), 128'd4);
    chk("bp_idle", 128'(req_ready), 128'd1);

    tick;
    req_reg = 3'd1; req_id = 2'd0; req_valid = 1'b1; n = 0; acc = 0;
    for (int k = 0; k < 40 && n < 8; k++) begin
      #1;
      if (row_valid) begin
        nr = n < 4 ? 3'd1 : 3'd5;
        chk("b2b_idx", 128'(row_idx), 128'(n % 4));
        chk("b2b_data", row_data, rowval(nr, 2'(n % 4)));
        chk("b2b_id", 128'(row_id), n < 4 ? 128'd0 : 128'd3);
        n++;
      end
      go = req_valid && req_ready;
      if (go && acc == 1) chk("b2b_second_after_drain", 128'(n), 128'd4);
      tick;
      if (go) begin
        acc++;
        if (acc == 1) begin req_reg = 3'd5; req_id = 2'd3; end
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_rows", 128'(n), 128'd8);
    chk("b2b_accepts", 128'(acc), 128'd2);
    tick;

    row_ready = 1'b1; req_reg = 3'd2; req_id = 2'd1; req_valid = 1'b1;
    tick; req_valid = 1'b0;
    repeat (1 + EXTRA) tick;
    #1; chk("f_row0", 128'(row_idx), 128'd0);
    tick; #1; chk("f_row1", 128'(row_idx), 128'd1);
    tick;
    row_ready = 1'b0; flush = 1'b1; #1;
    chk("f_ready_forced", 128'(req_ready), 128'd0);
    tick; flush = 1'b0; row_ready = 1'b1; #1;
    chk("f_valid", 128'(row_valid), 128'd0);
    chk("f_busy", 128'(busy), 128'd0);
    chk("f_req_ready", 128'(req_ready), 128'd1);
    repeat (3) begin
      tick; #1;
      chk("f_no_rows", 128'(row_valid), 128'd0);
    end
    req_reg = 3'd0; req_id = 2'd0; req_valid = 1'b1; flush = 1'b1; #1;
    chk("fc_ready_forced", 128'(req_ready), 128'd0);
    tick; flush = 1'b0; req_valid = 1'b0; #1;
    chk("fc_dropped_busy", 128'(busy), 128'd0);
    chk("fc_dropped_valid", 128'(row_valid), 128'd0);
    run_basic(3'd0, 2'd3);

    row_ready = 1'b1; req_reg = 3'd7; req_id = 2'd2; req_valid = 1'b1;
    tick; req_valid = 1'b0;
    repeat (1 + EXTRA) tick;
    #1; chk("r_pre_valid", 128'(row_valid), 128'd1);
    rst = 1'b1; #1;
    chk("r_valid", 128'(row_valid), 128'd0);
    chk("r_req_ready", 128'(req_ready), 128'd1);
    chk("r_busy", 128'(busy), 128'd0);
    chk("r_data", row_data, 128'd0);
    tick; rst = 1'b0; #1;
    chk("r_after_valid", 128'(row_valid), 128'd0);
    run_basic(3'd4, 2'd1);

`ifdef QUADRILATERO_RF_READER_HAZARD_EN
    wbusy = 8'h10; req_reg = 3'd4; req_id = 2'd2; req_valid = 1'b1;
    tick; req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hz_wait_valid", 128'(row_valid), 128'd0);
      chk("hz_wait_busy", 128'(busy), 128'd1);
      tick;
    end
    wbusy = 8'h00; #1;
    chk("hz_clear_valid", 128'(row_valid), 128'd0);
    tick; #1;
    chk("hz_read_valid", 128'(row_valid), 128'd0);
    chk("hz_read_rowaddr", 128'(rf_rrowaddr), 128'd0);
    tick;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hz_idx", 128'(row_idx), 128'(i));
      chk("hz_data", row_data, rowval(3'd4, 2'(i)));
      chk("hz_last", 128'(row_last), 128'(i == 3));
      tick;
    end
    #1; chk("hz_idle", 128'(req_ready), 128'd1);
`else
    wbusy = 8'h10;
    run_basic(3'd4, 2'd2);
    wbusy = 8'h00;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/quadrilatero_rf_row_reader.md
Name: quadrilatero_rf_row_reader

Overview:
- Read-side client of the matrix register file: accepts a "read register rN" request, issues one row read per cycle on a single regfile read port, and streams the rows out over a valid/ready interface.
- Feeds the matrix store path (rows to memory) and any consumer that needs a whole register serialised row by row.
- Regfile read data is combinational (same cycle as address). This block registers it through a 2-entry output FIFO, so downstream back-pressure never reaches the regfile path.

Parameters:
- N_REGS, 8, number of matrix registers.
- RLEN, 128, bits per register row.
- N_ROWS (localparam), RLEN/32, rows per register.
- ID_W, 2, width of the request tag carried with every row.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  read request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_reg_i  in  $clog2(N_REGS)  register to read.
- req_id_i  in  ID_W  tag echoed on every row.
- flush_i  in  1  synchronous abort of the current request.
- rf_raddr_o  out  $clog2(N_REGS)  regfile read-port register address.
- rf_rrowaddr_o  out  $clog2(N_ROWS)  regfile read-port row address.
- rf_rdata_i  in  RLEN  regfile row data, combinational from the address.
- rf_wbusy_i  in  N_REGS  per-register "write in flight" flags. Used only with the optional feature.
- row_valid_o  out  1  output row valid.
- row_ready_i  in  1  consumer ready.
- row_data_o  out  RLEN  row data.
- row_idx_o  out  $clog2(N_ROWS)  row index.
- row_id_o  out  ID_W  request tag.
- row_last_o  out  1  asserted on row N_ROWS-1.
- busy_o  out  1  high whenever state != IDLE or the FIFO is non-empty.

Behaviour:
- Reset (rst_i=1, asynchronous): state=IDLE, row counter=0, FIFO empty. All outputs are 0 except req_ready_o=1.
- States and transitions:
  - IDLE: req_ready_o=1. On valid&ready, latch reg/id, clear the counter, go to STREAM (or HOLD with the feature enabled).
  - STREAM: each cycle the FIFO can accept, issue a read:
    - rf_raddr_o=latched reg, rf_rrowaddr_o=counter.
    - Push {rf_rdata_i, counter, id, counter==N_ROWS-1} into the FIFO on the same edge.
    - Increment the counter.
    - After pushing row N_ROWS-1, go to DRAIN.
  - DRAIN: no reads. Go to IDLE when the FIFO becomes empty, including the cycle its last entry pops.
- FIFO can accept = count<2, or count==2 with a pop this cycle. A simultaneous push and pop keeps count unchanged.
- Outputs: row_valid_o = FIFO non-empty. FIFO head drives the row_* outputs. Pop on row_valid_o&row_ready_i. Rows emerge in index order.
- Read port outputs when not issuing: rf_raddr_o and rf_rrowaddr_o hold their last values; the regfile read has no side effects.
- Latency:
  - Request accepted at edge T; row 0 read during cycle T+1; row_valid_o=1 in cycle T+2.
  - With row_ready_i held high, one row per cycle. The last row is visible in cycle T+1+N_ROWS.
  - req_ready_o returns to 1 the cycle after the last pop.
- No new request is accepted until the previous stream has fully drained (req_ready_o=0 outside IDLE).
- Back-pressure: with row_ready_i=0 the FIFO fills to 2 and reads stall. The counter holds, and no row is skipped or duplicated.
- flush_i=1 (any state): FIFO emptied, counter cleared, state=IDLE on the next edge, row_valid_o=0 from the next cycle. A flush coincident with a request in IDLE drops the request, and req_ready_o is forced to 0 in that cycle.
- Reset mid-stream: same effect as flush_i, but immediate. No partial rows are emitted afterwards.
- Counter width is $clog2(N_ROWS). Wrap-around is never used, because the transition to DRAIN occurs at N_ROWS-1.

Optional Feature:
- Macro: QUADRILATERO_RF_READER_HAZARD_EN.
- Defined:
  - An accepted request enters HOLD and waits while rf_wbusy_i[reg] is 1.
  - It moves to STREAM on the first cycle the bit is 0, adding at least one cycle of latency. A clear busy bit costs exactly one extra cycle.
  - flush_i also exits HOLD.
- Undefined: no HOLD state, rf_wbusy_i is ignored, and reads start immediately after acceptance.

Test Plan:
- Basic stream: row_ready_i=1, request reg=3, id=2. Expect 4 rows idx 0..3 carrying regfile rows 3/0..3/3, all id=2, row_last_o only on idx 3, row_valid_o first seen at T+2, and req_ready_o=1 after the last pop.
- Back-pressure: row_ready_i toggled 1,0,0,1,0,1... Expect all 4 rows exactly once, in order, and at most 2 rf reads ahead of consumption.
- Back-to-back: hold req_valid_i high with reg=1 then reg=5. Expect the second acceptance only after the first stream's last pop, and 8 rows total with correct ids.
- Flush mid-stream: flush_i pulsed after row 1 is popped. Expect row_valid_o=0 the next cycle, busy_o=0, and no further rows. A new request (reg=0) then streams normally from idx 0.
- Async reset: rst_i asserted between clock edges during STREAM. Expect row_valid_o=0 and req_ready_o=1 immediately, without waiting for a clock edge.
- Hazard (macro defined): rf_wbusy_i[4]=1 for 5 cycles, then request reg=4. Expect no rf read until the bit clears, then the normal 4-row stream. With the macro undefined, the read starts at T+1.
